// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 UART receiver with rdy/clr_rdy handshake.
// Ports: clk, rst (async high), RX, clr_rdy -> rx_data, rdy, frm_err.
// Option: `define UART_RCV_MAJORITY_EN for 2-of-3 bit voting.
module uart_cmd_rcv #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic          rx_ff1;
  logic          rx_ff2;
  logic          rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          fall;
  logic          stb;
  logic          act;
  logic          bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  assign fall = rx_prev & ~rx_ff2;
  assign stb  = (state != IDLE) &&
                (baud_cnt == '0);

`ifdef UART_RCV_MAJORITY_EN
  // hist[1]/hist[0] hold rx_ff2 at strobe-1
  // and strobe; rx_ff2 is strobe+1 when
  // the delayed strobe acts.
  logic [1:0] hist;
  logic       stb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist  <= 2'b11;
      stb_d <= 1'b0;
    end else begin
      hist  <= {hist[0], rx_ff2};
      stb_d <= stb;
    end
  end

  assign act     = stb_d;
  assign bit_val = (hist[1] & hist[0]) |
                   (hist[1] & rx_ff2)  |
                   (hist[0] & rx_ff2);
`else
  assign act     = stb;
  assign bit_val = rx_ff2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      if (clr_rdy)
        rdy <= 1'b0;
      // Counter free-runs in a frame; the
      // voting path only delays decisions.
      if (state != IDLE)
        baud_cnt <= stb ? FULL :
                    baud_cnt - CW'(1);
      unique case (state)
        IDLE: begin
          if (fall) begin
            baud_cnt <= HALF;
            rdy      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (act) begin
            if (!bit_val) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (act) begin
            shift   <= {bit_val, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7)
              state <= STOP;
          end
        end
        STOP: begin
          if (act) begin
            // Set beats a same-cycle clr_rdy.
            if (bit_val) begin
              rx_data <= shift;
              rdy     <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
